// File: rtl/multdiv_iterative_if.sv
// Handshake bundle between decode/execute and the iterative multiply/divide unit.
// The master issues start pulses with operands; the slave returns result, flags and busy.
interface multdiv_iterative_if #(
  parameter int DATA_WIDTH = 32
);
  logic                         ctrl_MULT;
  logic                         ctrl_DIV;
  logic signed [DATA_WIDTH-1:0] data_operandA;
  logic signed [DATA_WIDTH-1:0] data_operandB;
  logic        [DATA_WIDTH-1:0] data_result;
  logic                         data_exception;
  logic                         data_resultRDY;
  logic                         busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_iterative.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring, on magnitudes).
// One iteration per cycle; a start pulse in any state restarts with the new operands.
module multdiv_iterative #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input logic                clock,
  input logic                reset,
  multdiv_iterative_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  // acc is the Booth P register or the divide remainder; mcand is Booth M or the divisor magnitude
  logic signed [W:0]    acc;
  logic signed [W:0]    mcand;
  logic [W-1:0]         q;
  logic                 q_m1;
  logic                 neg;

  logic signed [W:0]    booth_sum;
  logic [W:0]           rem_sh;
  logic [W:0]           trial;

  function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v);
    return v[W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Product fits in signed W bits only when product[2W-1:W-1] is all-equal.
  function automatic logic mul_overflow(input logic [W-1:0] hi, input logic lo_msb);
    return !((&{hi, lo_msb}) || !(|{hi, lo_msb}));
  endfunction

  // Applies the quotient sign; a positive quotient of magnitude 2^(W-1) is unrepresentable.
  function automatic logic [W:0] div_finish(input logic [W-1:0] qmag, input logic negate);
    logic [W-1:0] r;
    r = negate ? (~qmag + 1'b1) : qmag;
    return {~negate & qmag[W-1], r};
  endfunction

  always_comb begin
    booth_sum = acc;
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
    rem_sh = {acc[W-1:0], q[W-1]};
    trial  = rem_sh - $unsigned(mcand);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      acc                <= '0;
      mcand              <= '0;
      q                  <= '0;
      q_m1               <= 1'b0;
      neg                <= 1'b0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= 1'b0;
    end else begin
      bus.data_resultRDY <= 1'b0;
      if (bus.ctrl_MULT || bus.ctrl_DIV) begin
        state    <= bus.ctrl_MULT ? MUL : DIV;
        cnt      <= '0;
        acc      <= '0;
        q_m1     <= 1'b0;
        // Busy stays up across a restart so the pipeline never sees a one-cycle gap.
        bus.busy <= (state != IDLE);
        if (bus.ctrl_MULT) begin
          mcand <= {bus.data_operandA[W-1], bus.data_operandA};
          q     <= bus.data_operandB;
          neg   <= 1'b0;
        end else begin
          mcand <= {1'b0, magnitude(bus.data_operandB)};
          q     <= magnitude(bus.data_operandA);
          neg   <= bus.data_operandA[W-1] ^ bus.data_operandB[W-1];
        end
      end else begin
        case (state)
          MUL: begin
            bus.busy <= 1'b1;
            if (cnt == LAST_ITER) begin
              state              <= DONE;
              bus.data_result    <= q;
              bus.data_exception <= mul_overflow(acc[W-1:0], q[W-1]);
              bus.data_resultRDY <= 1'b1;
            end else begin
              acc  <= booth_sum >>> 1;
              q    <= {booth_sum[0], q[W-1:1]};
              q_m1 <= q[0];
              cnt  <= cnt + 1'b1;
            end
          end
          DIV: begin
            bus.busy <= 1'b1;
            if (mcand == '0) begin
              state              <= DONE;
              bus.data_result    <= '0;
              bus.data_exception <= 1'b1;
              bus.data_resultRDY <= 1'b1;
            end else if (cnt == LAST_ITER) begin
              state                                 <= DONE;
              {bus.data_exception, bus.data_result} <= div_finish(q, neg);
              bus.data_resultRDY                    <= 1'b1;
            end else begin
              if (!trial[W]) begin
                acc <= trial;
                q   <= {q[W-2:0], 1'b1};
              end else begin
                acc <= rem_sh;
                q   <= {q[W-2:0], 1'b0};
              end
              cnt <= cnt + 1'b1;
            end
          end
          DONE: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_multdiv_iterative.sv
// Scoreboard bench for multdiv_iterative: directed corner cases plus random operations,
// with expected results from plain 64-bit arithmetic.
module tb_multdiv_iterative;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multdiv_iterative_if #(.DATA_WIDTH(32)) bus();
  multdiv_iterative #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [32:0] ref_mul(input int a, input int b);
    longint p, lim_hi, lim_lo;
    lim_hi = 2147483647;
    lim_lo = -2147483647 - 1;
    p = longint'(a) * longint'(b);
    return {(p > lim_hi) || (p < lim_lo), p[31:0]};
  endfunction

  function automatic logic [32:0] ref_div(input int a, input int b);
    longint qv;
    if (b == 0) return {1'b1, 32'h0};
    if (a == 32'h80000000 && b == -1) return {1'b1, 32'h80000000};
    qv = longint'(a) / longint'(b);
    return {1'b0, qv[31:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.data_resultRDY === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rdy: got rdy=1 expected rdy=0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", bus.data_result, mon_e.res);
        check("exception", {31'b0, bus.data_exception}, {31'b0, mon_e.exc});
        check("latency_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic issue(input logic mul, input logic div, input int a, input int b);
    logic [32:0] e;
    int lat;
    @(negedge clk);
    bus.ctrl_MULT     = mul;
    bus.ctrl_DIV      = div;
    bus.data_operandA = a;
    bus.data_operandB = b;
    exp_q.delete();
    @(posedge clk);
    #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    e   = mul ? ref_mul(a, b) : ref_div(a, b);
    lat = (!mul && b == 0) ? 1 : 33;
    exp_q.push_back('{e[31:0], e[32], cyc + lat});
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: got no rdy within %0d cycles expected rdy (cycle %0d)", budget, cyc);
      exp_q.delete();
    end
  endtask

  task automatic count_busy(input int want, input string name);
    int n, k;
    n = 0;
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (bus.busy) n++;
      else if (n > 0) break;
    end
    check(name, n, want);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_result"}, bus.data_result, 32'h0);
    check({tag, "_exception"}, {31'b0, bus.data_exception}, 32'h0);
    check({tag, "_rdy"}, {31'b0, bus.data_resultRDY}, 32'h0);
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, b;
    logic m;
    rst               = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    issue(1'b1, 1'b0, 7, -3);
    count_busy(33, "busy_cycles_mul");
    wait_done(40);
    issue(1'b1, 1'b0, 32'h00010000, 32'h00010000);
    wait_done(40);
    issue(1'b1, 1'b0, 32'h80000000, 1);
    wait_done(40);
    issue(1'b1, 1'b0, 32'h80000000, 32'h80000000);
    wait_done(40);
    issue(1'b1, 1'b0, 32'h80000000, -1);
    wait_done(40);

    issue(1'b0, 1'b1, -7, 2);
    wait_done(40);
    issue(1'b0, 1'b1, 100, 7);
    wait_done(40);
    issue(1'b0, 1'b1, 32'h80000000, -1);
    wait_done(40);
    issue(1'b0, 1'b1, 32'h80000000, 3);
    wait_done(40);
    issue(1'b0, 1'b1, 5, 0);
    count_busy(1, "busy_cycles_div0");
    wait_done(40);

    issue(1'b1, 1'b0, 3, 4);
    repeat (9) @(negedge clk);
    issue(1'b0, 1'b1, 20, 5);
    wait_done(40);

    issue(1'b1, 1'b1, 6, 3);
    wait_done(40);

    issue(1'b1, 1'b0, 12345, -678);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_cleared("midop_reset");
    rst = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: a = 32'h80000000;
        2: b = -1;
        3, 4: begin
          a = int'($urandom_range(0, 200)) - 100;
          b = int'($urandom_range(0, 15)) - 8;
        end
        default: ;
      endcase
      m = 1'($urandom_range(0, 1));
      issue(m, !m, a, b);
      if (i % 7 == 3) repeat ($urandom_range(3, 25)) @(negedge clk);
      else wait_done(40);
    end
    wait_done(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
